// File: rtl/rr_arb_2to1_pkg.sv
// Shared types and constants for the 2:1 packet-locking round-robin arbiter.
// The source encoding doubles as the y_sel_out value.
package rr_arb_2to1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic other_src(input logic src);
    return (src == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/mux_2to1_data.sv
// Grant-driven select of one source word ({last, data}) for the output register.
module mux_2to1_data
  import rr_arb_2to1_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] a_word,
  input  logic [W-1:0] b_word,
  output logic [W-1:0] y_word
);

  // word select; an unknown select yields zeros rather than propagating either source
  always_comb begin
    y_word = '0;
    case (sel)
      SRC_A:   y_word = a_word;
      SRC_B:   y_word = b_word;
      default: y_word = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-source round-robin arbiter with packet locking and a single registered
// output stage (valid/ready on every channel, one beat per cycle sustained).
module rr_arb_2to1
  import rr_arb_2to1_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] a_data_in,
  input  logic              a_last_in,
  output logic              a_ready_out,
  input  logic              b_valid_in,
  input  logic [DATA_W-1:0] b_data_in,
  input  logic              b_last_in,
  output logic              b_ready_out,
  output logic              y_valid_out,
  output logic [DATA_W-1:0] y_data_out,
  output logic              y_last_out,
  output logic              y_sel_out,
  input  logic              y_ready_in
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic              prio_r;
  logic              prio_nxt_s;
  logic              y_valid_r;
  logic [DATA_W-1:0] y_data_r;
  logic              y_last_r;
  logic              y_sel_r;

  logic              free_s;
  logic              gnt_vld_s;
  logic              gnt_sel_s;
  logic              acc_s;
  logic [DATA_W:0]   mux_word_s;
  logic              mux_last_s;
  logic [DATA_W-1:0] mux_data_s;

  // grant: open packet owns the channel, otherwise prio breaks a tie
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_sel_s = SRC_A;
    case (state_r)
      IDLE: begin
        if (a_valid_in && (!b_valid_in || (prio_r == SRC_A))) begin
          gnt_vld_s = 1'b1;
          gnt_sel_s = SRC_A;
        end else if (b_valid_in) begin
          gnt_vld_s = 1'b1;
          gnt_sel_s = SRC_B;
        end else begin
          gnt_vld_s = 1'b0;
          gnt_sel_s = SRC_A;
        end
      end
      LOCK_A: begin
        gnt_vld_s = 1'b1;
        gnt_sel_s = SRC_A;
      end
      LOCK_B: begin
        gnt_vld_s = 1'b1;
        gnt_sel_s = SRC_B;
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_sel_s = SRC_A;
      end
    endcase
  end

  // rst_n_in gating keeps both readies low for the whole reset window
  assign free_s      = !y_valid_r || y_ready_in;
  assign a_ready_out = rst_n_in && free_s && gnt_vld_s && (gnt_sel_s == SRC_A);
  assign b_ready_out = rst_n_in && free_s && gnt_vld_s && (gnt_sel_s == SRC_B);
  assign acc_s       = (a_valid_in && a_ready_out) || (b_valid_in && b_ready_out);

  mux_2to1_data #(
    .W (DATA_W + 1)
  ) u_mux (
    .sel    (gnt_sel_s),
    .a_word ({a_last_in, a_data_in}),
    .b_word ({b_last_in, b_data_in}),
    .y_word (mux_word_s)
  );

  assign mux_last_s = mux_word_s[DATA_W];
  assign mux_data_s = mux_word_s[DATA_W-1:0];

  // next state and priority; only an accepted beat moves either
  always_comb begin
    state_nxt_s = state_r;
    prio_nxt_s  = prio_r;
    case (state_r)
      IDLE, LOCK_A, LOCK_B: begin
        if (acc_s) begin
          if (mux_last_s) begin
            state_nxt_s = IDLE;
            prio_nxt_s  = other_src(gnt_sel_s);
          end else begin
            state_nxt_s = (gnt_sel_s == SRC_B) ? LOCK_B : LOCK_A;
            prio_nxt_s  = prio_r;
          end
        end else begin
          state_nxt_s = state_r;
          prio_nxt_s  = prio_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        prio_nxt_s  = SRC_A;
      end
    endcase
  end

  // arbitration state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
      prio_r  <= SRC_A;
    end else begin
      state_r <= state_nxt_s;
      prio_r  <= prio_nxt_s;
    end
  end

  // output register: load on accept (even while draining), else clear on drain, else hold
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_valid_r <= 1'b0;
      y_data_r  <= '0;
      y_last_r  <= 1'b0;
      y_sel_r   <= 1'b0;
    end else if (acc_s) begin
      y_valid_r <= 1'b1;
      y_data_r  <= mux_data_s;
      y_last_r  <= mux_last_s;
      y_sel_r   <= gnt_sel_s;
    end else if (y_ready_in) begin
      y_valid_r <= 1'b0;
    end else begin
      y_valid_r <= y_valid_r;
    end
  end

  assign y_valid_out = y_valid_r;
  assign y_data_out  = y_data_r;
  assign y_last_out  = y_last_r;
  assign y_sel_out   = y_sel_r;

endmodule

// File: tb/tb_rr_arb_2to1.sv
// Directed scenarios followed by a random valid/ready stress run, all checked
// against a packet-level reference model of the arbiter.
module tb_rr_arb_2to1;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       a_valid_in, a_last_in, a_ready_out;
  logic [7:0] a_data_in;
  logic       b_valid_in, b_last_in, b_ready_out;
  logic [7:0] b_data_in;
  logic       y_valid_out, y_last_out, y_sel_out, y_ready_in;
  logic [7:0] y_data_out;

  int checks = 0;
  int errors = 0;

  // reference model: open packet owner (-1 none), preferred source, output beat
  int         m_open;
  logic       m_prio;
  logic       m_yv, m_yl, m_ys;
  logic [7:0] m_yd;

  logic a_acc, b_acc, obs_a_ready, obs_b_ready;
  logic [7:0] pk [3] = '{8'h11, 8'h22, 8'h33};
  logic       rr_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  rr_arb_2to1 #(.DATA_W(8)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .a_valid_in  (a_valid_in),
    .a_data_in   (a_data_in),
    .a_last_in   (a_last_in),
    .a_ready_out (a_ready_out),
    .b_valid_in  (b_valid_in),
    .b_data_in   (b_data_in),
    .b_last_in   (b_last_in),
    .b_ready_out (b_ready_out),
    .y_valid_out (y_valid_out),
    .y_data_out  (y_data_out),
    .y_last_out  (y_last_out),
    .y_sel_out   (y_sel_out),
    .y_ready_in  (y_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_open = -1;
    m_prio = 1'b0;
    m_yv   = 1'b0;
    m_yd   = 8'h00;
    m_yl   = 1'b0;
    m_ys   = 1'b0;
  endtask

  // one clock: check readies against model, clock, advance model, check outputs
  task automatic cycle;
    int   g;
    logic free, er_a, er_b;
    #1;
    free = !m_yv || y_ready_in;
    g = -1;
    if (m_open >= 0) g = m_open;
    else if (a_valid_in && (!b_valid_in || m_prio == 1'b0)) g = 0;
    else if (b_valid_in) g = 1;
    er_a = free && (g == 0);
    er_b = free && (g == 1);
    chk("a_ready", 32'(a_ready_out), 32'(er_a));
    chk("b_ready", 32'(b_ready_out), 32'(er_b));
    obs_a_ready = a_ready_out;
    obs_b_ready = b_ready_out;
    a_acc = a_valid_in && a_ready_out;
    b_acc = b_valid_in && b_ready_out;
    @(posedge clk_in);
    if (er_a && a_valid_in) begin
      m_yv = 1'b1; m_yd = a_data_in; m_yl = a_last_in; m_ys = 1'b0;
      if (a_last_in) begin m_open = -1; m_prio = 1'b1; end
      else m_open = 0;
    end else if (er_b && b_valid_in) begin
      m_yv = 1'b1; m_yd = b_data_in; m_yl = b_last_in; m_ys = 1'b1;
      if (b_last_in) begin m_open = -1; m_prio = 1'b0; end
      else m_open = 1;
    end else if (y_ready_in) begin
      m_yv = 1'b0;
    end
    #1;
    chk("y_valid", 32'(y_valid_out), 32'(m_yv));
    if (m_yv) begin
      chk("y_data", 32'(y_data_out), 32'(m_yd));
      chk("y_last", 32'(y_last_out), 32'(m_yl));
      chk("y_sel",  32'(y_sel_out),  32'(m_ys));
    end
  endtask

  initial begin
    logic [6:0] seq_a, seq_b, exp_a, exp_b;
    logic       pv, pl, ps;
    logic [7:0] pd, exp_d;
    int         owner;

    rst_n_in = 1'b0;
    a_valid_in = 1'b1; a_data_in = 8'h00; a_last_in = 1'b1;
    b_valid_in = 1'b1; b_data_in = 8'h00; b_last_in = 1'b1;
    y_ready_in = 1'b1;
    a_acc = 1'b0; b_acc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_y_valid", 32'(y_valid_out), 32'h0);
    chk("rst_y_data",  32'(y_data_out),  32'h0);
    chk("rst_y_last",  32'(y_last_out),  32'h0);
    chk("rst_y_sel",   32'(y_sel_out),   32'h0);
    chk("rst_a_ready", 32'(a_ready_out), 32'h0);
    chk("rst_b_ready", 32'(b_ready_out), 32'h0);
    rst_n_in = 1'b1;

    // alternating single-beat packets from reset: A,B,A,B
    a_data_in = 8'h10; b_data_in = 8'h20;
    for (int k = 0; k < 4; k++) begin
      exp_d = rr_sel[k] ? b_data_in : a_data_in;
      cycle();
      chk("rr_sel",  32'(y_sel_out),  32'(rr_sel[k]));
      chk("rr_data", 32'(y_data_out), 32'(exp_d));
      if (a_acc) a_data_in = a_data_in + 8'h01;
      if (b_acc) b_data_in = b_data_in + 8'h01;
    end

    // A 3-beat packet locks out a continuously valid B
    b_data_in = 8'h44; b_last_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_data_in = pk[k];
      a_last_in = (k == 2);
      cycle();
      chk("pkt_b_ready", 32'(obs_b_ready), 32'h0);
      chk("pkt_data",    32'(y_data_out),  32'(pk[k]));
      chk("pkt_sel",     32'(y_sel_out),   32'h0);
    end
    a_valid_in = 1'b0;
    cycle();
    chk("pkt_after_b", 32'(y_data_out), 32'h44);
    chk("pkt_after_sel", 32'(y_sel_out), 32'h1);
    b_valid_in = 1'b0;

    // backpressure: four stalled cycles, then back-to-back release
    y_ready_in = 1'b0;
    a_valid_in = 1'b1; a_data_in = 8'h55; a_last_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stall_valid", 32'(y_valid_out), 32'h1);
      chk("stall_data",  32'(y_data_out),  32'h44);
      chk("stall_sel",   32'(y_sel_out),   32'h1);
      chk("stall_a_rdy", 32'(obs_a_ready), 32'h0);
      chk("stall_b_rdy", 32'(obs_b_ready), 32'h0);
    end
    y_ready_in = 1'b1;
    cycle();
    chk("release_valid", 32'(y_valid_out), 32'h1);
    chk("release_data",  32'(y_data_out),  32'h55);
    a_valid_in = 1'b0;
    cycle();
    chk("drain_valid", 32'(y_valid_out), 32'h0);

    // only B valid while prio is A: immediate grant, prio stays A
    b_valid_in = 1'b1; b_data_in = 8'h66; b_last_in = 1'b1;
    cycle();
    b_data_in = 8'h77;
    cycle();
    chk("onlyb_ready", 32'(obs_b_ready), 32'h1);
    chk("onlyb_data",  32'(y_data_out),  32'h77);
    a_valid_in = 1'b1; a_data_in = 8'h78; a_last_in = 1'b1;
    b_data_in = 8'h79;
    cycle();
    chk("onlyb_prio_a", 32'(y_sel_out), 32'h0);

    // reset in the middle of a B packet
    a_valid_in = 1'b0;
    b_data_in = 8'h88; b_last_in = 1'b0;
    cycle();
    a_valid_in = 1'b1;
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_valid", 32'(y_valid_out), 32'h0);
    chk("async_rst_a_rdy", 32'(a_ready_out), 32'h0);
    chk("async_rst_b_rdy", 32'(b_ready_out), 32'h0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    model_reset();
    a_data_in = 8'h99; a_last_in = 1'b1;
    b_data_in = 8'hAA; b_last_in = 1'b1;
    cycle();
    chk("post_rst_a_rdy", 32'(obs_a_ready), 32'h1);
    chk("post_rst_sel",   32'(y_sel_out),   32'h0);
    chk("post_rst_data",  32'(y_data_out),  32'h99);

    a_valid_in = 1'b0; b_valid_in = 1'b0;
    cycle();
    cycle();

    // random stress: data = {source, per-source sequence number}
    seq_a = 7'd0; seq_b = 7'd0; exp_a = 7'd0; exp_b = 7'd0;
    owner = -1;
    a_acc = 1'b0; b_acc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!a_valid_in || a_acc) begin
        a_valid_in = ($urandom_range(0, 99) < 60);
        if (a_valid_in) begin
          a_data_in = {1'b0, seq_a};
          seq_a = seq_a + 7'd1;
          a_last_in = ($urandom_range(0, 2) == 0);
        end
      end
      if (!b_valid_in || b_acc) begin
        b_valid_in = ($urandom_range(0, 99) < 60);
        if (b_valid_in) begin
          b_data_in = {1'b1, seq_b};
          seq_b = seq_b + 7'd1;
          b_last_in = ($urandom_range(0, 2) == 0);
        end
      end
      y_ready_in = ($urandom_range(0, 99) < 70);
      pv = y_valid_out; pd = y_data_out; pl = y_last_out; ps = y_sel_out;
      if (y_valid_out && y_ready_in) begin
        chk("stress_src_tag", 32'(y_data_out[7]), 32'(y_sel_out));
        if (owner >= 0) chk("stress_interleave", 32'(y_sel_out), 32'(owner));
        if (y_sel_out) begin
          chk("stress_seq_b", 32'(y_data_out[6:0]), 32'(exp_b));
          exp_b = exp_b + 7'd1;
        end else begin
          chk("stress_seq_a", 32'(y_data_out[6:0]), 32'(exp_a));
          exp_a = exp_a + 7'd1;
        end
        owner = y_last_out ? -1 : int'(y_sel_out);
      end
      cycle();
      if (pv && !y_ready_in)
        chk("stress_hold", 32'({y_valid_out, y_last_out, y_sel_out, y_data_out}),
            32'({1'b1, pl, ps, pd}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
